// File: rtl/ram_ctrl_pkg.sv
// Shared constants and state encoding for the 32x4 RAM controller.
package ram_ctrl_pkg;
  localparam int AW    = 5;
  localparam int DW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam logic [DW-1:0] CLEAR_VAL = '0;

  typedef enum logic {
    CLEAR = 1'b0,
    SERVE = 1'b1
  } state_e;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. gnt[0] = A, gnt[1] = B.
// The pointer resets to B so A wins the first tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt
);
  logic last_b_q;  // 1: B was granted last

  // Grant the single requester, or on a tie the one not granted last
  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      if (req == 2'b11) gnt = last_b_q ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  // Pointer moves on every grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          last_b_q <= 1'b1;
    else if (|gnt)    last_b_q <= gnt[1];
  end
endmodule

// File: rtl/ram32x4_arbiter.sv
// Shares one registered-input 32x4 RAM between requesters A and B.
// Sweeps the RAM to CLEAR_VAL after reset / clear_req, then serves
// single-word transactions with a fixed one-cycle read return.
module ram32x4_arbiter #(
  parameter int            AW        = ram_ctrl_pkg::AW,
  parameter int            DW        = ram_ctrl_pkg::DW,
  parameter int            DEPTH     = ram_ctrl_pkg::DEPTH,
  parameter logic [DW-1:0] CLEAR_VAL = ram_ctrl_pkg::CLEAR_VAL
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_req,
  output logic          busy,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
);
  import ram_ctrl_pkg::*;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ram_req_t;

  state_e        state_q, state_n;
  logic [AW-1:0] cnt_q, cnt_n;
  logic [AW-1:0] hold_addr_q;
  logic [DW-1:0] hold_din_q;
  logic [1:0]    gnt;
  logic          arb_en;
  logic          a_rv_q, b_rv_q;
  ram_req_t      a_r, b_r;

  assign a_r = '{we: a_we, addr: a_addr, data: a_wdata};
  assign b_r = '{we: b_we, addr: b_addr, data: b_wdata};

  // A pending clear pre-empts any same-cycle request
  assign arb_en = (state_q == SERVE) && !clear_req;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({b_req, a_req}),
    .enable (arb_en),
    .gnt    (gnt)
  );

  assign a_gnt = gnt[0];
  assign b_gnt = gnt[1];
  assign busy  = (state_q == CLEAR);

  // Next state, clear counter and RAM port mux; idle cycles hold addr/din
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    ram_we   = 1'b0;
    ram_addr = hold_addr_q;
    ram_din  = hold_din_q;
    case (state_q)
      CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = cnt_q;
        ram_din  = CLEAR_VAL;
        cnt_n    = cnt_q + AW'(1);
        if (cnt_q == LAST) begin
          state_n = SERVE;
          cnt_n   = '0;
        end
      end
      SERVE: begin
        if (clear_req) begin
          state_n = CLEAR;
          cnt_n   = '0;
        end else if (gnt[0]) begin
          ram_we   = a_r.we;
          ram_addr = a_r.addr;
          ram_din  = a_r.data;
        end else if (gnt[1]) begin
          ram_we   = b_r.we;
          ram_addr = b_r.addr;
          ram_din  = b_r.data;
        end
      end
      default: state_n = CLEAR;
    endcase
    // Keep the RAM quiet while reset is held
    if (rst) begin
      ram_we   = 1'b0;
      ram_addr = '0;
      ram_din  = '0;
    end
  end

  // State, counter and held RAM address/data registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      hold_addr_q <= '0;
      hold_din_q  <= '0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      hold_addr_q <= ram_addr;
      hold_din_q  <= ram_din;
    end
  end

  // Read return valid: one cycle after a granted read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rv_q <= 1'b0;
      b_rv_q <= 1'b0;
    end else begin
      a_rv_q <= gnt[0] && !a_we;
      b_rv_q <= gnt[1] && !b_we;
    end
  end

  assign a_rvalid = a_rv_q;
  assign b_rvalid = b_rv_q;
  assign a_rdata  = a_rv_q ? ram_dout : '0;
  assign b_rdata  = b_rv_q ? ram_dout : '0;
endmodule

// File: tb/tb_ram32x4_arbiter.sv
// Directed bench for ram32x4_arbiter with a behavioural 32x4 RAM.
module tb_ram32x4_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       clear_req;
  logic       busy;
  logic       a_req, a_we, b_req, b_we;
  logic [4:0] a_addr, b_addr;
  logic [3:0] a_wdata, b_wdata;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [3:0] a_rdata, b_rdata;
  logic [4:0] ram_addr;
  logic [3:0] ram_din, ram_dout;
  logic       ram_we;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram32x4_arbiter dut (
    .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout)
  );

  // Registered-input RAM; loads a nonzero pattern while rst is high so
  // the clear sweep is observable.
  logic [3:0] mem [32];
  logic [4:0] cap_addr;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= 4'(i) ^ 4'hC;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_din;
    end
    cap_addr <= ram_addr;
  end
  assign ram_dout = mem[cap_addr];

  typedef struct {
    logic       clr;
    logic       a_req, a_we; logic [4:0] a_addr; logic [3:0] a_wd;
    logic       b_req, b_we; logic [4:0] b_addr; logic [3:0] b_wd;
    logic       e_agnt, e_bgnt, e_we; logic [4:0] e_addr; logic [3:0] e_din;
    logic       e_arv; logic [3:0] e_ard;
    logic       e_brv; logic [3:0] e_brd;
    logic       e_busy;
  } vec_t;

  function automatic vec_t mk(
    input logic clr,
    input logic ar, input logic aw, input logic [4:0] aa, input logic [3:0] ad,
    input logic br, input logic bw, input logic [4:0] ba, input logic [3:0] bd,
    input logic eag, input logic ebg, input logic ewe,
    input logic [4:0] eaddr, input logic [3:0] edin,
    input logic earv, input logic [3:0] eard,
    input logic ebrv, input logic [3:0] ebrd, input logic ebusy);
    vec_t v;
    v.clr = clr;
    v.a_req = ar; v.a_we = aw; v.a_addr = aa; v.a_wd = ad;
    v.b_req = br; v.b_we = bw; v.b_addr = ba; v.b_wd = bd;
    v.e_agnt = eag; v.e_bgnt = ebg; v.e_we = ewe; v.e_addr = eaddr;
    v.e_din = edin; v.e_arv = earv; v.e_ard = eard;
    v.e_brv = ebrv; v.e_brd = ebrd; v.e_busy = ebusy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    clear_req = 0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
  endtask

  // n sweep cycles starting at address 0; requests must not be granted
  task automatic sweep_chk(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, " busy"}, busy, 1);
      chk({tag, " ram_we"}, ram_we, 1);
      chk({tag, " ram_addr"}, ram_addr, i);
      chk({tag, " ram_din"}, ram_din, 0);
      chk({tag, " a_gnt"}, a_gnt, 0);
      chk({tag, " b_gnt"}, b_gnt, 0);
      @(posedge clk); #1;
    end
  endtask

  vec_t vecs [13];

  initial begin
    vecs[0]  = mk(0, 1,0,12,0, 0,0,0,0,   1,0,0,12,0, 0,0, 0,0, 0);
    vecs[1]  = mk(0, 0,0,0,0,  0,0,0,0,   0,0,0,12,0, 1,0, 0,0, 0);
    vecs[2]  = mk(0, 1,1,3,3,  0,0,0,0,   1,0,1,3,3,  0,0, 0,0, 0);
    vecs[3]  = mk(0, 0,0,0,0,  1,1,7,7,   0,1,1,7,7,  0,0, 0,0, 0);
    vecs[4]  = mk(0, 1,1,5,4'hA, 0,0,0,0, 1,0,1,5,4'hA, 0,0, 0,0, 0);
    vecs[5]  = mk(0, 1,0,5,0,  0,0,0,0,   1,0,0,5,0,  0,0, 0,0, 0);
    vecs[6]  = mk(0, 0,0,0,0,  1,1,9,4'hF, 0,1,1,9,4'hF, 1,4'hA, 0,0, 0);
    vecs[7]  = mk(0, 1,0,3,0,  1,0,7,0,   1,0,0,3,0,  0,0, 0,0, 0);
    vecs[8]  = mk(0, 1,0,3,0,  1,0,7,0,   0,1,0,7,0,  1,3, 0,0, 0);
    vecs[9]  = mk(0, 1,0,3,0,  1,0,7,0,   1,0,0,3,0,  0,0, 1,7, 0);
    vecs[10] = mk(0, 1,0,3,0,  1,0,7,0,   0,1,0,7,0,  1,3, 0,0, 0);
    vecs[11] = mk(0, 0,0,0,0,  0,0,0,0,   0,0,0,7,0,  0,0, 1,7, 0);
    vecs[12] = mk(1, 1,0,9,0,  0,0,0,0,   0,0,0,7,0,  0,0, 0,0, 0);

    // Reset state
    idle_inputs();
    rst = 1;
    @(negedge clk);
    chk("rst busy", busy, 1);
    chk("rst ram_we", ram_we, 0);
    chk("rst ram_addr", ram_addr, 0);
    chk("rst ram_din", ram_din, 0);
    chk("rst a_rvalid", a_rvalid, 0);
    chk("rst b_rvalid", b_rvalid, 0);
    @(posedge clk); #1;
    rst = 0;
    a_req = 1;  // held through the sweep, must not be granted
    sweep_chk(32, "init");
    a_req = 0;

    // Table-driven serve phase, ending with clear_req + a_req together
    for (int i = 0; i < 13; i++) begin
      clear_req = vecs[i].clr;
      a_req = vecs[i].a_req; a_we = vecs[i].a_we;
      a_addr = vecs[i].a_addr; a_wdata = vecs[i].a_wd;
      b_req = vecs[i].b_req; b_we = vecs[i].b_we;
      b_addr = vecs[i].b_addr; b_wdata = vecs[i].b_wd;
      @(negedge clk);
      chk($sformatf("v%0d a_gnt", i), a_gnt, vecs[i].e_agnt);
      chk($sformatf("v%0d b_gnt", i), b_gnt, vecs[i].e_bgnt);
      chk($sformatf("v%0d ram_we", i), ram_we, vecs[i].e_we);
      chk($sformatf("v%0d ram_addr", i), ram_addr, vecs[i].e_addr);
      chk($sformatf("v%0d ram_din", i), ram_din, vecs[i].e_din);
      chk($sformatf("v%0d a_rvalid", i), a_rvalid, vecs[i].e_arv);
      chk($sformatf("v%0d a_rdata", i), a_rdata, vecs[i].e_ard);
      chk($sformatf("v%0d b_rvalid", i), b_rvalid, vecs[i].e_brv);
      chk($sformatf("v%0d b_rdata", i), b_rdata, vecs[i].e_brd);
      chk($sformatf("v%0d busy", i), busy, vecs[i].e_busy);
      @(posedge clk); #1;
    end

    // Clear entered; A keeps asking to read addr 9 (was 4'hF)
    clear_req = 0; b_req = 0;
    sweep_chk(32, "clr");
    @(negedge clk);
    chk("post-clr busy", busy, 0);
    chk("post-clr a_gnt", a_gnt, 1);
    chk("post-clr ram_addr", ram_addr, 9);
    @(posedge clk); #1;
    a_req = 0;
    @(negedge clk);
    chk("rd9 a_rvalid", a_rvalid, 1);
    chk("rd9 a_rdata", a_rdata, 0);
    @(posedge clk); #1;

    // B writes 20 = 6, reads it, then clear_req next cycle
    b_req = 1; b_we = 1; b_addr = 20; b_wdata = 6;
    @(negedge clk);
    chk("b wr20 gnt", b_gnt, 1);
    @(posedge clk); #1;
    b_we = 0; b_wdata = 0;
    @(negedge clk);
    chk("b rd20 gnt", b_gnt, 1);
    @(posedge clk); #1;
    b_req = 0; clear_req = 1;
    @(negedge clk);
    chk("clr-after-rd b_gnt", b_gnt, 0);
    chk("clr-after-rd b_rvalid", b_rvalid, 1);
    chk("clr-after-rd b_rdata", b_rdata, 6);
    chk("clr-after-rd busy", busy, 0);
    @(posedge clk); #1;
    clear_req = 0;

    // Reset when the sweep reaches address 12
    sweep_chk(12, "pre-rst");
    @(negedge clk);
    chk("cnt12 ram_addr", ram_addr, 12);
    #1 rst = 1;
    #1;
    chk("mid-rst ram_we", ram_we, 0);
    chk("mid-rst ram_addr", ram_addr, 0);
    chk("mid-rst busy", busy, 1);
    @(posedge clk); #1;
    chk("mid-rst held ram_we", ram_we, 0);
    rst = 0;
    sweep_chk(32, "restart");
    @(negedge clk);
    chk("restart busy", busy, 0);
    @(posedge clk); #1;

    // Read 20 after the restarted sweep
    a_req = 1; a_we = 0; a_addr = 20; a_wdata = 0;
    @(negedge clk);
    chk("rd20 a_gnt", a_gnt, 1);
    @(posedge clk); #1;
    a_req = 0;
    @(negedge clk);
    chk("rd20 a_rvalid", a_rvalid, 1);
    chk("rd20 a_rdata", a_rdata, 0);
    chk("rd20 b_rvalid", b_rvalid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram32x4_arbiter.md
Name: ram32x4_arbiter

Overview:
- Controller sharing one 32x4 registered-input RAM between two requesters, A and B, using round-robin arbitration.
- After reset, and on request, it sweeps the whole RAM to a clear value.
- It then serves single-word read/write transactions with a req/gnt handshake and a fixed-latency read return.
- Sits between the user-side requesters (switch/key logic, display scanner) and the 32x4 RAM instance.

Parameters:
- AW, 5, address width
- DW, 4, data width
- DEPTH, 32, words swept by clear (2**AW)
- CLEAR_VAL, 4'h0, value written during clear sweep

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- clear_req  in  1  pulse: start a new clear sweep
- busy  out  1  high while clear sweep in progress
- a_req  in  1  requester A transaction request
- a_we  in  1  A: 1 = write, 0 = read
- a_addr  in  AW  A address
- a_wdata  in  DW  A write data
- a_gnt  out  1  A request accepted this cycle
- a_rvalid  out  1  A read data valid
- a_rdata  out  DW  A read data
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for requester B
- ram_addr  out  AW  to RAM Address
- ram_din  out  DW  to RAM DataIn
- ram_we  out  1  to RAM Write
- ram_dout  in  DW  from RAM DataOut

Behaviour:
- RAM model: captures addr/din/we at posedge clk; write takes effect from captured values; dout reflects captured address, combinationally.
- Reset (rst=1, async):
  - state=CLEAR, clear counter=0, rr pointer=B (A wins first tie)
  - busy=1; a/b_gnt=0; a/b_rvalid=0
  - ram_we=0, ram_addr=0, ram_din=0 while rst high
- CLEAR state:
  - ram_we=1, ram_addr=cnt, ram_din=CLEAR_VAL, all gnt=0
  - cnt increments each cycle; after cnt=DEPTH-1 the next state is SERVE; exactly DEPTH write cycles
  - busy=1 throughout, falls in first SERVE cycle
  - clear_req in CLEAR: ignored (no restart); reset mid-sweep restarts at cnt=0
- SERVE state:
  - gnt is combinational (Mealy): granted requester's we/addr/wdata drive ram_*; RAM captures at the following edge.
  - Arbitration:
    - only one req: grant it
    - both: grant the requester not granted last; pointer updates on every grant
  - No grant: ram_we=0; ram_addr/ram_din hold last values.
  - Throughput: one grant per cycle; back-to-back grants allowed.
  - Requester holds req/we/addr/wdata stable until gnt; dropping req before gnt is legal (no transaction).
- Read return:
  - x_rvalid is registered: 1 in the cycle after x_gnt with we=0, else 0.
  - x_rdata = ram_dout (combinational pass-through), qualified by x_rvalid; value otherwise don't-care, driven 0 when rvalid=0.
  - Writes give no response.
- clear_req in SERVE:
  - wins over same-cycle requests: no gnt that cycle; CLEAR entered at next edge with cnt=0
  - a read granted in the previous cycle still delivers rvalid/rdata (captured address is still its own)
- Ordering:
  - write then read of the same address on consecutive grants returns the new data
  - A and B are ordered strictly by grant order

Decomposition:
- Shared package/header ram_ctrl_pkg: AW, DW, DEPTH localparams; state encoding CLEAR=1'b0, SERVE=1'b1.
- One sub-module, rr_arbiter2:
  - inputs: clk, rst, req[1:0], enable
  - outputs: gnt[1:0] one-hot/zero
  - holds the last-grant pointer
- Top-level holds the FSM, clear counter, mux and rvalid registers.

Test Plan:
- Reset release -> busy=1 for exactly 32 cycles; ram_we=1, ram_addr 0..31, ram_din=0; then busy=0, any subsequent read returns 4'h0.
- A writes addr 5 = 4'hA, next cycle A reads addr 5 -> a_gnt both cycles, a_rvalid one cycle after read gnt, a_rdata=4'hA; b_rvalid stays 0.
- a_req and b_req held continuously (A reads 3, B reads 7, preloaded 4'h3/4'h7) -> grants alternate A,B,A,B starting with A; rdata 3,7,3,7 on the matching rvalid.
- clear_req asserted same cycle as a_req, with addr 9 previously = 4'hF -> no a_gnt that cycle, busy=1 for 32 cycles, then a read of addr 9 = 4'h0; a_gnt resumes only after busy falls.
- rst asserted at cnt=12 mid-sweep, released -> ram_we=0 during reset; sweep restarts at addr 0 and runs a full 32 cycles.
- B read of addr 20 granted, clear_req the next cycle -> b_rvalid=1 with the pre-clear data, then sweep starts.
